adder_stim_chk: RTL and testbench
=================================

// Module: adder_stim_chk
// PURPOSE
// - Self-checking driver for the opposite end of the adder_top interface: generates operands a/b/c/d, consumes s.
// - Predicts a+b+c+d mod 2^DIM, aligns the prediction to the adder latency, and compares it against s.
// - Counts mismatches and records the first failing vector.
// - Sits beside adder_top in hardware self-test and simulation top levels on the same clk.
// PARAMETERS
// - DIM       14            operand/sum width; legal range 2..16
// - LATENCY   2             clk cycles from operands driven to matching s; legal range 1..8
// - N_VEC     1024          vectors issued per run; legal range 1..65535
// - SEED0     32'hACE1_2468 initial state of LFSR0; zero is replaced by 32'h1
// - SEED1     32'h1357_BDF0 initial state of LFSR1; zero is replaced by 32'h1
// PORTS
// - clk       in   1      rising-edge clock shared with adder_top
// - rst       in   1      asynchronous, active-high reset
// - start     in   1      one-cycle pulse; begins a run when IDLE or DONE
// - mode      in   1      0 = LFSR random operands, 1 = corner sequence; sampled at start
// - a,b,c,d   out  DIM    signed operands to adder_top
// - s         in   DIM    signed sum from adder_top
// - busy      out  1      high in RUN and DRAIN
// - done      out  1      high in DONE; held until next start or rst
// - pass      out  1      valid when done: err_cnt == 0
// - err_cnt   out  16     mismatch count; saturates at 16'hFFFF
// - first_err out  16     index of the first mismatching vector; 16'hFFFF if none
// BEHAVIOUR
// - Reset (async): state IDLE; a=b=c=d=0; busy=done=pass=0; err_cnt=0; first_err=16'hFFFF;
//   LFSRs load their seeds; valid pipe cleared. Reset mid-run abandons the run with no report.
// - FSM IDLE -start-> RUN -(N_VEC issued)-> DRAIN -(LATENCY cycles)-> DONE -start-> RUN.
// - start is ignored in RUN/DRAIN. start in DONE clears counters and first_err but does not reseed LFSRs.
// - RUN: drive one new vector every clk; vec_idx counts 0..N_VEC-1.
// - Random mode: two 32-bit Galois LFSRs, taps 32'h8020_0003, each stepped once per vector.
//   a=L0[DIM-1:0]; b=L0[31-:DIM]; c=L1[DIM-1:0]; d=L1[31-:DIM].
// - Corner mode: vector k uses pattern k mod 4, with MAX=2^(DIM-1)-1 and MIN=-2^(DIM-1):
//   0: all MAX; 1: all MIN; 2: a=MAX,b=1,c=MIN,d=-1; 3: all -1.
// - Expected value: sum of four sign-extended operands truncated to DIM bits, so overflow wraps.
//   Example: DIM=14, all MAX gives 16'h...3FFC wrapped, i.e. -4.
// - The expected value, a valid bit and vec_idx enter a LATENCY-deep shift pipe together.
//   When the pipe-out valid is high and s != expected: err_cnt += 1 (saturating); first_err is
//   loaded with the pipe-out index if it is still 16'hFFFF.
// - DRAIN: operands hold their last value and no new valid enters the pipe;
//   compares continue for LATENCY cycles, then the FSM enters DONE.
// - Operands are registered; they change only on the clk edge that issues a vector.
// - Outside RUN, s is ignored except while valids are draining. Comparison uses all DIM bits.
// STRUCTURE
// - Package adder_tb_pkg: LFSR taps constant, FSM state encoding (IDLE/RUN/DRAIN/DONE),
//   function corner_vec(k, DIM).
// - Sub-module lfsr32 (seed parameter, step enable, 32-bit state out), instantiated twice.
// - Remainder is flat: FSM, vector counter, expected-value pipe, comparator and error counters.
// TESTING
// - DIM=14, LATENCY=2, with adder_top connected, mode=0, N_VEC=1024:
//   done after 1024+2 cycles in RUN/DRAIN; pass=1; err_cnt=0; first_err=16'hFFFF.
// - mode=1, N_VEC=4: operands follow MAX/MIN/mixed/-1; expected values -4, 0, -1, -4
//   (MIN*4 wraps to 0); pass=1.
// - Bench forces s ^= 1 on the cycle vector 5 returns:
//   err_cnt=1, first_err=5, pass=0.
// - LATENCY=3 against a 2-cycle adder: large err_cnt (>1000 for N_VEC=1024); first_err=0.
// - Assert rst in mid-RUN (vector 300): all outputs return to reset values on that edge;
//   a new start reruns from the seeds and passes.
// - start pulsed during RUN: ignored and vec count unchanged; start in DONE launches a second run
//   with counters cleared and pass=1.

Source files
------------

// File: rtl/adder_tb_pkg.sv
// Shared constants and helpers for the adder stimulus/checker block:
// LFSR taps, FSM encoding, LFSR step function and the corner-vector table.
package adder_tb_pkg;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Right-shifting Galois step: the bit shifted out selects the tap XOR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] st);
        logic [31:0] nxt;
        if (st[0]) begin
            nxt = (st >> 1) ^ LFSR_TAPS;
        end else begin
            nxt = st >> 1;
        end
        return nxt;
    endfunction

    // Returns {a, b, c, d}, each a 16-bit two's-complement value meaningful in its low dim bits.
    function automatic logic [63:0] corner_vec(input logic [1:0] k, input int dim);
        int          max_i;
        logic [15:0] max_v;
        logic [15:0] min_v;
        logic [63:0] vec;
        max_i = (32'sd1 <<< (dim - 32'sd1)) - 32'sd1;
        max_v = max_i[15:0];
        min_v = ~max_v;
        case (k)
            2'd0:    vec = {max_v, max_v, max_v, max_v};
            2'd1:    vec = {min_v, min_v, min_v, min_v};
            2'd2:    vec = {max_v, 16'h0001, min_v, 16'hFFFF};
            2'd3:    vec = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
            default: vec = {max_v, max_v, max_v, max_v};
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with a seed parameter and step enable; a zero seed is
// replaced by 1 so the register can never lock up.
module lfsr32
    import adder_tb_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] state
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

    logic [31:0] state_r;

    // LFSR register: reloads the seed on reset, advances once per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SEED_EFF;
        end else if (en) begin
            state_r <= lfsr_step(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/adder_stim_chk.sv
// Stimulus generator and latency-aligned checker for a four-input adder:
// drives a/b/c/d, predicts the wrapped sum and compares it against s.
module adder_stim_chk
    import adder_tb_pkg::*;
#(
    parameter int          DIM     = 14,
    parameter int          LATENCY = 2,
    parameter int          N_VEC   = 1024,
    parameter logic [31:0] SEED0   = 32'hACE1_2468,
    parameter logic [31:0] SEED1   = 32'h1357_BDF0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    output logic signed [DIM-1:0] a,
    output logic signed [DIM-1:0] b,
    output logic signed [DIM-1:0] c,
    output logic signed [DIM-1:0] d,
    input  logic signed [DIM-1:0] s,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_cnt,
    output logic [15:0]           first_err
);

    localparam logic [15:0] N_VEC16 = 16'(N_VEC);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

    logic [1:0]     state_r;
    logic [1:0]     state_nxt_s;
    logic           mode_r;
    logic [15:0]    issued_r;
    logic [3:0]     drain_r;
    logic [DIM-1:0] a_r, b_r, c_r, d_r;
    logic           busy_r, done_r, pass_r;
    logic [15:0]    err_r, first_r;
    logic [15:0]    err_nxt_s, first_nxt_s;

    logic           start_ok_s, issue_s, mode_eff_s, step_s, mis_s;
    logic [15:0]    idx_s;
    logic [31:0]    l0_s, l1_s;
    logic [63:0]    cv_s;
    logic [DIM-1:0] opa_s, opb_s, opc_s, opd_s, exp_s;

    // Stage 0 is loaded together with the operand registers, so stage LATENCY
    // lines up with the adder output that the compare samples.
    logic           pv_r [0:LATENCY];
    logic [DIM-1:0] pe_r [0:LATENCY];
    logic [15:0]    pi_r [0:LATENCY];

    lfsr32 #(.SEED(SEED0)) u_lfsr0 (.clk(clk), .rst(rst), .en(step_s), .state(l0_s));
    lfsr32 #(.SEED(SEED1)) u_lfsr1 (.clk(clk), .rst(rst), .en(step_s), .state(l1_s));

    // Issue control: the start edge issues vector 0, RUN issues the rest.
    always_comb begin
        start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        issue_s    = start_ok_s || ((state_r == ST_RUN) && (issued_r != N_VEC16));
        idx_s      = start_ok_s ? 16'd0 : issued_r;
        mode_eff_s = start_ok_s ? mode : mode_r;
        step_s     = issue_s && !mode_eff_s;
    end

    assign cv_s = corner_vec(idx_s[1:0], DIM);

    // Operand selection and the wrapped DIM-bit expected sum.
    always_comb begin
        if (mode_eff_s) begin
            opa_s = cv_s[48 +: DIM];
            opb_s = cv_s[32 +: DIM];
            opc_s = cv_s[16 +: DIM];
            opd_s = cv_s[0 +: DIM];
        end else begin
            opa_s = l0_s[DIM-1:0];
            opb_s = l0_s[31 -: DIM];
            opc_s = l1_s[DIM-1:0];
            opd_s = l1_s[31 -: DIM];
        end
        exp_s = opa_s + opb_s + opc_s + opd_s;
    end

    // Next-state logic for the run sequencer.
    always_comb begin
        case (state_r)
            ST_IDLE:  state_nxt_s = start_ok_s ? ST_RUN : ST_IDLE;
            ST_RUN:   state_nxt_s = (issued_r == N_VEC16) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt_s = (drain_r == LAT_M1) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_nxt_s = start_ok_s ? ST_RUN : ST_DONE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Compare at pipe-out and next values of the saturating error counter and first-error index.
    always_comb begin
        mis_s = pv_r[LATENCY] && ($unsigned(s) != pe_r[LATENCY]);
        if (start_ok_s) begin
            err_nxt_s   = 16'd0;
            first_nxt_s = 16'hFFFF;
        end else if (mis_s) begin
            err_nxt_s   = (err_r == 16'hFFFF) ? err_r : (err_r + 16'd1);
            first_nxt_s = (first_r == 16'hFFFF) ? pi_r[LATENCY] : first_r;
        end else begin
            err_nxt_s   = err_r;
            first_nxt_s = first_r;
        end
    end

    // Sequencer state, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mode_r   <= 1'b0;
            issued_r <= 16'd0;
            drain_r  <= 4'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pass_r   <= 1'b0;
            err_r    <= 16'd0;
            first_r  <= 16'hFFFF;
        end else begin
            state_r  <= state_nxt_s;
            mode_r   <= start_ok_s ? mode : mode_r;
            issued_r <= start_ok_s ? 16'd1 : (issue_s ? (issued_r + 16'd1) : issued_r);
            drain_r  <= (state_r == ST_DRAIN) ? (drain_r + 4'd1) : 4'd0;
            busy_r   <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r   <= (state_nxt_s == ST_DONE);
            pass_r   <= (state_nxt_s == ST_DONE) && (err_nxt_s == 16'd0);
            err_r    <= err_nxt_s;
            first_r  <= first_nxt_s;
        end
    end

    // Operand registers: they change only on an issuing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            c_r <= '0;
            d_r <= '0;
        end else if (issue_s) begin
            a_r <= opa_s;
            b_r <= opb_s;
            c_r <= opc_s;
            d_r <= opd_s;
        end else begin
            a_r <= a_r;
            b_r <= b_r;
            c_r <= c_r;
            d_r <= d_r;
        end
    end

    // Expected-value pipe carrying valid, prediction and vector index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                pv_r[i] <= 1'b0;
                pe_r[i] <= '0;
                pi_r[i] <= 16'd0;
            end
        end else begin
            pv_r[0] <= issue_s;
            pe_r[0] <= exp_s;
            pi_r[0] <= idx_s;
            for (int i = 1; i <= LATENCY; i++) begin
                pv_r[i] <= pv_r[i-1];
                pe_r[i] <= pe_r[i-1];
                pi_r[i] <= pi_r[i-1];
            end
        end
    end

    logic unused_s;
    assign unused_s = ^{l0_s, l1_s, cv_s};

    assign a         = a_r;
    assign b         = b_r;
    assign c         = c_r;
    assign d         = d_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_cnt   = err_r;
    assign first_err = first_r;

endmodule

// File: tb/tb_adder_stim_chk.sv
// Directed bench: two checkers (latency 2 and 3) against a 2-cycle adder model,
// with a scoreboard of predicted operand vectors.
module tb_adder_stim_chk;

    localparam int DIM = 14;
    localparam int N   = 1024;

    typedef struct packed {
        logic [DIM-1:0] a;
        logic [DIM-1:0] b;
        logic [DIM-1:0] c;
        logic [DIM-1:0] d;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, mode, inj;
    logic [DIM-1:0] a, b, c, d, s, r1, sr;
    logic [DIM-1:0] a3, b3, c3, d3, s3, r13;
    logic busy, done, pass, busy3, done3, pass3;
    logic [15:0] err_cnt, first_err, err3, first3;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t corner_tab[4];
    logic [31:0] m0, m1;
    bit   aborted;

    always #5 clk = ~clk;

    adder_stim_chk #(.DIM(DIM), .LATENCY(2), .N_VEC(N)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .a(a), .b(b), .c(c), .d(d), .s(s),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .first_err(first_err));

    adder_stim_chk #(.DIM(DIM), .LATENCY(3), .N_VEC(N)) dut3 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .a(a3), .b(b3), .c(c3), .d(d3), .s(s3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .first_err(first3));

    // Two-cycle adder models; the main one can flip bit 0 of its sum on demand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1 <= '0; sr <= '0; r13 <= '0; s3 <= '0;
        end else begin
            r1 <= a + b + c + d;      sr <= r1;
            r13 <= a3 + b3 + c3 + d3; s3 <= r13;
        end
    end
    assign s = sr ^ {{(DIM-1){1'b0}}, inj};

    function automatic logic [31:0] lfsr_nx(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reseed();
        m0 = 32'hACE1_2468;
        m1 = 32'h1357_BDF0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a"}, 32'(a), 32'd0);
        chk({tag, "_b"}, 32'(b), 32'd0);
        chk({tag, "_c"}, 32'(c), 32'd0);
        chk({tag, "_d"}, 32'(d), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
        chk({tag, "_first"}, 32'(first_err), 32'h0000_FFFF);
    endtask

    // One run: predict all vectors, pulse start, compare operands every cycle, time done.
    task automatic run(input logic m, input int start_at, input int inject_at, input int abort_at);
        vec_t v;
        logic [DIM-1:0] sum;
        logic [DIM-1:0] corner_sum [4];
        int j;
        corner_sum[0] = 14'h3FFC; corner_sum[1] = 14'h0000;
        corner_sum[2] = 14'h3FFF; corner_sum[3] = 14'h3FFC;
        aborted = 1'b0;
        sb.delete();
        for (int k = 0; k < N; k++) begin
            if (!m) begin
                v = {m0[DIM-1:0], m0[31 -: DIM], m1[DIM-1:0], m1[31 -: DIM]};
                m0 = lfsr_nx(m0);
                m1 = lfsr_nx(m1);
            end else begin
                v = corner_tab[k % 4];
            end
            sb.push_back(v);
        end
        @(negedge clk); start = 1'b1; mode = m;
        @(negedge clk); start = 1'b0;
        chk("start_done_low", 32'(done), 32'd0);
        for (int k = 0; k < N; k++) begin
            v = sb.pop_front();
            chk($sformatf("vec%0d_a", k), 32'(a), 32'(v.a));
            chk($sformatf("vec%0d_b", k), 32'(b), 32'(v.b));
            chk($sformatf("vec%0d_c", k), 32'(c), 32'(v.c));
            chk($sformatf("vec%0d_d", k), 32'(d), 32'(v.d));
            chk($sformatf("vec%0d_busy", k), 32'(busy), 32'd1);
            if (m && k < 4) begin
                sum = a + b + c + d;
                chk($sformatf("corner%0d_sum", k), 32'(sum), 32'(corner_sum[k]));
            end
            start = (k == start_at);
            inj   = (k == inject_at + 2);
            if (k == abort_at) begin
                start = 1'b0; inj = 1'b0;
                rst = 1'b1;
                #1;
                chk_reset_vals("abort");
                aborted = 1'b1;
                sb.delete();
                return;
            end
            @(negedge clk);
        end
        start = 1'b0; inj = 1'b0;
        j = N;
        while (done !== 1'b1 && j < N + 20) begin
            @(negedge clk);
            j++;
        end
        chk("done_cycles", 32'(j), 32'(N + 2));
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int j3;
        corner_tab[0] = {14'h1FFF, 14'h1FFF, 14'h1FFF, 14'h1FFF};
        corner_tab[1] = {14'h2000, 14'h2000, 14'h2000, 14'h2000};
        corner_tab[2] = {14'h1FFF, 14'h0001, 14'h2000, 14'h3FFF};
        corner_tab[3] = {14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h3FFF};
        rst = 1'b1; start = 1'b0; mode = 1'b0; inj = 1'b0;
        reseed();
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Random run with a stray start pulse in the middle of RUN.
        run(1'b0, 100, -10, -1);
        chk("a_pass", 32'(pass), 32'd1);
        chk("a_err", 32'(err_cnt), 32'd0);
        chk("a_first", 32'(first_err), 32'h0000_FFFF);
        j3 = 0;
        while (done3 !== 1'b1 && j3 < 10) begin
            @(negedge clk);
            j3++;
        end
        chk("lat3_done", 32'(done3), 32'd1);
        chk("lat3_err_large", 32'(err3 > 16'd1000), 32'd1);
        chk("lat3_first", 32'(first3), 32'd0);
        chk("lat3_pass", 32'(pass3), 32'd0);

        // Second run from DONE with a corrupted sum for vector 5.
        run(1'b0, -1, 5, -1);
        chk("inj_err", 32'(err_cnt), 32'd1);
        chk("inj_first", 32'(first_err), 32'd5);
        chk("inj_pass", 32'(pass), 32'd0);

        // Restart from DONE clears the counters.
        run(1'b0, -1, -10, -1);
        chk("c_pass", 32'(pass), 32'd1);
        chk("c_err", 32'(err_cnt), 32'd0);
        chk("c_first", 32'(first_err), 32'h0000_FFFF);

        run(1'b1, -1, -10, -1);
        chk("corner_pass", 32'(pass), 32'd1);
        chk("corner_err", 32'(err_cnt), 32'd0);

        // Reset in the middle of a random run, then rerun from the seeds.
        run(1'b0, -1, -10, 300);
        chk("abort_seen", 32'(aborted), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        reseed();
        run(1'b0, -1, -10, -1);
        chk("f_pass", 32'(pass), 32'd1);
        chk("f_err", 32'(err_cnt), 32'd0);
        chk("f_first", 32'(first_err), 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
